// File: rtl/spi_pkg.sv
// Shared SPI types: the control-register word layout and the request-arbiter state encoding.
package spi_pkg;

   localparam int ARB_NW = 10;

   typedef struct packed {
      logic [1:0]        spi_mode;
      logic              all_0s;
      logic              all_1s;
      logic              cs_ctrl;
      logic [ARB_NW-1:0] n_rx_end;
      logic [ARB_NW-1:0] n_tx_end;
      logic              send;
   } palabra_control;

   typedef enum logic [2:0] {
      ARB_IDLE       = 3'd0,
      ARB_LOAD       = 3'd1,
      ARB_WAIT_START = 3'd2,
      ARB_WAIT_END   = 3'd3,
      ARB_DONE       = 3'd4,
      ARB_ABORT      = 3'd5
   } arb_state_e;

   // all_1s dominates all_0s; every field not supplied by a requester stays zero
   function automatic palabra_control arb_ctrl_word(
      input logic [ARB_NW-1:0] n_tx,
      input logic [ARB_NW-1:0] n_rx,
      input logic              cs_ctrl,
      input logic              all_1s,
      input logic              all_0s
   );
      palabra_control w;
      w          = '0;
      w.send     = 1'b1;
      w.n_tx_end = n_tx;
      w.n_rx_end = n_rx;
      w.cs_ctrl  = cs_ctrl;
      w.all_1s   = all_1s;
      w.all_0s   = all_0s & ~all_1s;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr.
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] sel,
   output logic             any
);

   // Scan from ptr around the ring; the first hit wins
   always_comb begin
      sel = '0;
      any = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         automatic int   k   = (int'(ptr) + i) % N_REQ;
         automatic logic hit = req[k] & ~any;
         sel[k] = hit;
         any    = any | hit;
      end
   end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin owner of the shared SPI master: loads one requester's control word,
// follows the send bit to completion and aborts stuck transfers via a watchdog.
module spi_req_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int N_W       = ARB_NW,
   parameter int WD_CYCLES = 200000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [N_REQ*N_W-1:0] req_n_tx_i,
   input  logic [N_REQ*N_W-1:0] req_n_rx_i,
   input  logic [N_REQ-1:0]     req_cs_ctrl_i,
   input  logic [N_REQ-1:0]     req_all_1s_i,
   input  logic [N_REQ-1:0]     req_all_0s_i,
   output logic [N_REQ-1:0]     gnt_o,
   output logic [N_REQ-1:0]     done_o,
   output logic                 err_o,
   output logic                 busy_o,
   output logic                 ctrl_wr_o,
   output palabra_control       ctrl_word_o,
   input  logic                 ctrl_send_i
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WD_W  = $clog2(WD_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   arb_state_e      r_state, w_next;
   logic [PTR_W-1:0] r_ptr, r_gnt_idx, w_idx, w_ptr_nxt;
   logic [WD_W-1:0]  r_wd;
   logic [N_REQ-1:0] w_sel, r_gnt, r_done;
   logic             w_any, w_wd_exp, r_err, r_busy, r_ctrl_wr;
   logic [N_W-1:0]   w_n_tx, w_n_rx;
   logic             w_cs, w_a1, w_a0;
   palabra_control   r_ctrl_word;

   rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req (req_i),
      .ptr (r_ptr),
      .sel (w_sel),
      .any (w_any)
   );

   // One-hot select of the winner's fields and index
   always_comb begin
      w_n_tx = '0;
      w_n_rx = '0;
      w_cs   = 1'b0;
      w_a1   = 1'b0;
      w_a0   = 1'b0;
      w_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_n_tx = w_n_tx | (req_n_tx_i[k*N_W +: N_W] & {N_W{w_sel[k]}});
         w_n_rx = w_n_rx | (req_n_rx_i[k*N_W +: N_W] & {N_W{w_sel[k]}});
         w_cs   = w_cs | (req_cs_ctrl_i[k] & w_sel[k]);
         w_a1   = w_a1 | (req_all_1s_i[k] & w_sel[k]);
         w_a0   = w_a0 | (req_all_0s_i[k] & w_sel[k]);
         w_idx  = w_idx | (PTR_W'(k) & {PTR_W{w_sel[k]}});
      end
   end

   assign w_wd_exp  = (r_wd == WD_LAST);
   assign w_ptr_nxt = (r_gnt_idx == PTR_LAST) ? '0 : r_gnt_idx + PTR_W'(1);

   // Next-state logic; a real send transition takes precedence over a watchdog expiry
   always_comb begin
      w_next = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) w_next = ARB_LOAD;
            else       w_next = ARB_IDLE;
         end
         ARB_LOAD: w_next = ARB_WAIT_START;
         ARB_WAIT_START: begin
            if (ctrl_send_i)   w_next = ARB_WAIT_END;
            else if (w_wd_exp) w_next = ARB_ABORT;
            else               w_next = ARB_WAIT_START;
         end
         ARB_WAIT_END: begin
            if (!ctrl_send_i)  w_next = ARB_DONE;
            else if (w_wd_exp) w_next = ARB_ABORT;
            else               w_next = ARB_WAIT_END;
         end
         ARB_DONE:  w_next = ARB_IDLE;
         ARB_ABORT: w_next = ARB_IDLE;
         default:   w_next = ARB_IDLE;
      endcase
   end

   // State, watchdog, rotation pointer and grant bookkeeping
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= ARB_IDLE;
         r_wd      <= '0;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next == r_state) &&
             (r_state == ARB_WAIT_START || r_state == ARB_WAIT_END))
            r_wd <= r_wd + WD_W'(1);
         else
            r_wd <= '0;
         if (w_next == ARB_DONE || w_next == ARB_ABORT)
            r_ptr <= w_ptr_nxt;
         else
            r_ptr <= r_ptr;
         if (r_state == ARB_IDLE && w_any) begin
            r_gnt     <= w_sel;
            r_gnt_idx <= w_idx;
         end else if (w_next == ARB_IDLE) begin
            r_gnt     <= '0;
            r_gnt_idx <= r_gnt_idx;
         end else begin
            r_gnt     <= r_gnt;
            r_gnt_idx <= r_gnt_idx;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_done      <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_ctrl_wr   <= 1'b0;
         r_ctrl_word <= '0;
      end else begin
         r_busy    <= (w_next != ARB_IDLE);
         r_err     <= (w_next == ARB_ABORT);
         r_ctrl_wr <= (w_next == ARB_LOAD) || (w_next == ARB_ABORT);
         if (w_next == ARB_DONE || w_next == ARB_ABORT)
            r_done <= r_gnt;
         else
            r_done <= '0;
         if (r_state == ARB_IDLE && w_next == ARB_LOAD)
            r_ctrl_word <= arb_ctrl_word(w_n_tx, w_n_rx, w_cs, w_a1, w_a0);
         else
            r_ctrl_word <= '0;
      end
   end

   assign gnt_o       = r_gnt;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign busy_o      = r_busy;
   assign ctrl_wr_o   = r_ctrl_wr;
   assign ctrl_word_o = r_ctrl_word;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: stimulus queues expected writes and completions,
// a negedge monitor pops and compares whenever the DUT writes or completes.
module tb_spi_req_arbiter;
   import spi_pkg::*;

   localparam int N_REQ = 2;
   localparam int N_W   = ARB_NW;
   localparam int WD    = 16;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic [N_REQ-1:0]     req_i = '0;
   logic [N_REQ*N_W-1:0] req_n_tx_i, req_n_rx_i;
   logic [N_REQ-1:0]     req_cs_ctrl_i, req_all_1s_i, req_all_0s_i;
   logic [N_REQ-1:0]     gnt_o, done_o;
   logic                 err_o, busy_o, ctrl_wr_o;
   palabra_control       ctrl_word_o;
   logic                 ctrl_send_i = 1'b0;

   spi_req_arbiter #(.N_REQ(N_REQ), .N_W(N_W), .WD_CYCLES(WD)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .req_n_tx_i    (req_n_tx_i),
      .req_n_rx_i    (req_n_rx_i),
      .req_cs_ctrl_i (req_cs_ctrl_i),
      .req_all_1s_i  (req_all_1s_i),
      .req_all_0s_i  (req_all_0s_i),
      .gnt_o         (gnt_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .busy_o        (busy_o),
      .ctrl_wr_o     (ctrl_wr_o),
      .ctrl_word_o   (ctrl_word_o),
      .ctrl_send_i   (ctrl_send_i)
   );

   always #50 clk_i = ~clk_i;

   typedef struct {
      logic [N_REQ-1:0] done;
      logic             err;
      int               lat;
   } done_exp_t;

   palabra_control   wr_q[$];
   done_exp_t        done_q[$];
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   int               last_wr_cyc = 0;
   logic [N_REQ-1:0] exp_gnt = '0;
   bit               gnt_chk = 1'b0;
   palabra_control   W0, W1;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic palabra_control mk_word(input logic [N_W-1:0] ntx, input logic [N_W-1:0] nrx,
                                              input logic cs, input logic a1, input logic a0);
      palabra_control w;
      w = '0;
      w.send = 1'b1;
      w.n_tx_end = ntx;
      w.n_rx_end = nrx;
      w.cs_ctrl = cs;
      w.all_1s = a1;
      w.all_0s = a0;
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: completions and control writes are checked against the scoreboard
   always @(negedge clk_i) begin
      if (rst_i) begin
         if (done_o != '0 || err_o) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", {60'd0, done_o, 1'b0, err_o}, 64'd0);
            end else begin
               done_exp_t e;
               e = done_q.pop_front();
               chk("done", {60'd0, done_o, 1'b0, err_o}, {60'd0, e.done, 1'b0, e.err});
               chk("done_latency", 64'(cyc - last_wr_cyc), 64'(e.lat));
            end
         end
         if (ctrl_wr_o) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_wr", 64'(ctrl_word_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("ctrl_word", 64'(ctrl_word_o), 64'(wr_q.pop_front()));
            end
            last_wr_cyc = cyc;
         end
         if (busy_o && done_o == '0 && gnt_chk)
            chk("gnt_held", 64'(gnt_o), 64'(exp_gnt));
      end
   end

   // mode 0: send held for hold cycles; 1: send never rises; 2: send never falls
   task automatic run_txn(input logic [N_REQ-1:0] req_v, input logic [N_REQ-1:0] g,
                          input palabra_control w, input int mode, input int hold,
                          input bit drop, input bit keep, output int wait_n);
      done_exp_t e;
      int n;
      wr_q.push_back(w);
      e.done = g;
      e.err  = (mode != 0);
      e.lat  = (mode == 0) ? hold + 2 : (mode == 1) ? WD + 1 : WD + 2;
      done_q.push_back(e);
      if (mode != 0) wr_q.push_back('0);
      req_i = req_v;
      wait_n = 0;
      do begin
         @(negedge clk_i);
         wait_n++;
      end while (!ctrl_wr_o && wait_n < 20);
      if (!ctrl_wr_o) chk("grant_timeout", 64'd0, 64'd1);
      exp_gnt = g;
      gnt_chk = 1'b1;
      if (drop) req_i = '0;
      @(posedge clk_i);
      #1;
      if (mode == 0) begin
         ctrl_send_i = 1'b1;
         repeat (hold) @(posedge clk_i);
         #1 ctrl_send_i = 1'b0;
      end else if (mode == 2) begin
         ctrl_send_i = 1'b1;
      end else begin
         ctrl_send_i = 1'b0;
      end
      n = 0;
      while (done_o == '0 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (done_o == '0) chk("done_timeout", 64'd0, 64'd1);
      gnt_chk = 1'b0;
      ctrl_send_i = 1'b0;
      if (!keep) req_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   initial begin
      int n;
      req_n_tx_i    = {10'd0,   10'd3};
      req_n_rx_i    = {10'h3FF, 10'd5};
      req_cs_ctrl_i = 2'b01;
      req_all_1s_i  = 2'b10;
      req_all_0s_i  = 2'b10;
      W0 = mk_word(10'd3, 10'd5, 1'b1, 1'b0, 1'b0);
      W1 = mk_word(10'd0, 10'h3FF, 1'b0, 1'b1, 1'b0);

      #10 rst_i = 1'b0;
      #1 chk("reset_values", {gnt_o, done_o, err_o, busy_o, ctrl_wr_o, 64'(ctrl_word_o)} >> 0,
             64'd0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;

      // single request, then ptr=1 makes requester 1 win a tie
      run_txn(2'b01, 2'b01, W0, 0, 10, 1'b0, 1'b0, n);
      chk("grant_latency", 64'(n), 64'd1);
      run_txn(2'b11, 2'b10, W1, 0, 1, 1'b0, 1'b0, n);

      // contention from reset: 0, 1, 0
      do_reset();
      run_txn(2'b11, 2'b01, W0, 0, 2, 1'b0, 1'b1, n);
      run_txn(2'b11, 2'b10, W1, 0, 2, 1'b0, 1'b1, n);
      run_txn(2'b11, 2'b01, W0, 0, 2, 1'b0, 1'b0, n);

      // watchdog aborts
      run_txn(2'b01, 2'b01, W0, 1, 0, 1'b0, 1'b0, n);
      run_txn(2'b10, 2'b10, W1, 2, 0, 1'b0, 1'b0, n);

      // withdrawn request still completes
      run_txn(2'b01, 2'b01, W0, 0, 3, 1'b1, 1'b0, n);

      // reset during WAIT_END
      wr_q.push_back(W0);
      req_i = 2'b01;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!ctrl_wr_o && n < 20);
      if (!ctrl_wr_o) chk("grant_timeout", 64'd0, 64'd1);
      @(posedge clk_i);
      #1 ctrl_send_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("busy_before_reset", 64'(busy_o), 64'd1);
      gnt_chk = 1'b0;
      rst_i = 1'b0;
      req_i = '0;
      ctrl_send_i = 1'b0;
      #1 chk("reset_mid", {gnt_o, done_o, err_o, busy_o, ctrl_wr_o, 64'(ctrl_word_o)} >> 0,
             64'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      run_txn(2'b10, 2'b10, W1, 0, 2, 1'b0, 1'b0, n);
      chk("regrant_latency", 64'(n), 64'd1);

      repeat (3) @(negedge clk_i);
      chk("queues_empty", 64'(wr_q.size() + done_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
